// File: rtl/deskew_ctrl_if.sv
// Bundle between the deskew sequencer and the per-lane deskew FIFOs.
// master = sequencer side, slave = lane/FIFO side.
interface deskew_ctrl_if #(
    parameter int NUM_LANES = 4,
    parameter int SKW       = 3
);
    logic                 link_en;
    logic [NUM_LANES-1:0] com_ahead;
    logic [NUM_LANES-1:0] fifo_not_empty;
    logic [2:0]           window_cnt;
    logic                 r_en;
    logic                 fifo_rst_n;
    logic                 aligned;
    logic                 deskew_err;
    logic [SKW-1:0]       skew_max;
    logic [7:0]           err_cnt;

    modport master (
        input  link_en,
        input  com_ahead,
        input  fifo_not_empty,
        output window_cnt,
        output r_en,
        output fifo_rst_n,
        output aligned,
        output deskew_err,
        output skew_max,
        output err_cnt
    );

    modport slave (
        output link_en,
        output com_ahead,
        output fifo_not_empty,
        input  window_cnt,
        input  r_en,
        input  fifo_rst_n,
        input  aligned,
        input  deskew_err,
        input  skew_max,
        input  err_cnt
    );
endinterface

// File: rtl/deskew_ctrl.sv
// Lane-deskew sequencer: opens the shared count-4 window, measures COM arrival skew
// across lanes, broadcasts the common read enable, and flushes/retrains on errors.
module deskew_ctrl #(
    parameter int NUM_LANES = 4,
    parameter int MAX_SKEW  = 3,
    parameter int SKW       = $clog2(MAX_SKEW + 2)
) (
    input  logic          clk_r_local,
    input  logic          rstn,
    deskew_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COUNT   = 3'd1,
        ST_HUNT    = 3'd2,
        ST_ALIGNED = 3'd3,
        ST_FLUSH   = 3'd4
    } state_t;

    localparam logic [SKW-1:0] SKEW_LIMIT = SKW'(MAX_SKEW);
    localparam logic [SKW-1:0] CNT_SAT    = SKW'(MAX_SKEW + 1);

    state_t               state_q;
    logic [2:0]           window_cnt_q;
    logic [NUM_LANES-1:0] mask_q;
    logic [SKW-1:0]       skew_cnt_q;
    logic [SKW-1:0]       loss_cnt_q;
    logic                 flush_cnt_q;
    logic                 fifo_rst_n_q;
    logic                 aligned_q;
    logic                 deskew_err_q;
    logic [SKW-1:0]       skew_max_q;
    logic [7:0]           err_cnt_q;

    logic [NUM_LANES-1:0] mask_d;
    logic [SKW-1:0]       skew_cnt_d;
    logic [SKW-1:0]       loss_cnt_d;
    logic                 hunt_started;
    logic                 all_arrived;
    logic                 any_arrived;
    logic                 hunt_overflow;
    logic                 partial;
    logic                 loss_trip;
    logic                 link_drop;
    logic                 err_hit;
    logic                 go_flush;

    // Per-lane arrival latch: a lane stays marked once its first COM is seen.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign mask_d[gi] = mask_q[gi] | bus.com_ahead[gi];
        end
    endgenerate

    assign hunt_started = |mask_q;
    assign all_arrived  = &mask_d;
    assign any_arrived  = |mask_d;

    // Skew is 0 in the first-arrival cycle and counts up from there.
    always_comb begin
        skew_cnt_d = '0;
        if (hunt_started) begin
            skew_cnt_d = (skew_cnt_q == CNT_SAT) ? skew_cnt_q : skew_cnt_q + SKW'(1);
        end
    end

    assign hunt_overflow = any_arrived & ~all_arrived & (skew_cnt_d >= SKEW_LIMIT);

    assign partial = (|bus.fifo_not_empty) & ~(&bus.fifo_not_empty);

    always_comb begin
        loss_cnt_d = '0;
        if (partial) begin
            loss_cnt_d = (loss_cnt_q == CNT_SAT) ? loss_cnt_q : loss_cnt_q + SKW'(1);
        end
    end

    assign loss_trip = partial & (loss_cnt_d == CNT_SAT);

    assign err_hit = ((state_q == ST_HUNT) & hunt_overflow) |
                     ((state_q == ST_ALIGNED) & loss_trip);

    assign link_drop = ~bus.link_en & ((state_q == ST_COUNT) |
                                       (state_q == ST_HUNT)  |
                                       (state_q == ST_ALIGNED));

    // An error wins over a simultaneous link drop so it is still pulsed and counted.
    assign go_flush = err_hit | link_drop;

    always_ff @(posedge clk_r_local or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            window_cnt_q <= 3'd0;
            mask_q       <= '0;
            skew_cnt_q   <= '0;
            loss_cnt_q   <= '0;
            flush_cnt_q  <= 1'b0;
            fifo_rst_n_q <= 1'b1;
            aligned_q    <= 1'b0;
            deskew_err_q <= 1'b0;
            skew_max_q   <= '0;
            err_cnt_q    <= 8'd0;
        end else begin
            deskew_err_q <= err_hit;
            if (err_hit && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end

            if (go_flush) begin
                state_q      <= ST_FLUSH;
                fifo_rst_n_q <= 1'b0;
                flush_cnt_q  <= 1'b0;
                window_cnt_q <= 3'd0;
                aligned_q    <= 1'b0;
                mask_q       <= '0;
                skew_cnt_q   <= '0;
                loss_cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        window_cnt_q <= 3'd0;
                        if (bus.link_en) begin
                            state_q <= ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        window_cnt_q <= window_cnt_q + 3'd1;
                        if (window_cnt_q == 3'd3) begin
                            state_q <= ST_HUNT;
                        end
                    end
                    ST_HUNT: begin
                        if (all_arrived) begin
                            state_q    <= ST_ALIGNED;
                            aligned_q  <= 1'b1;
                            skew_max_q <= skew_cnt_d;
                            mask_q     <= '0;
                            skew_cnt_q <= '0;
                            loss_cnt_q <= '0;
                        end else begin
                            mask_q     <= mask_d;
                            skew_cnt_q <= skew_cnt_d;
                        end
                    end
                    ST_ALIGNED: begin
                        loss_cnt_q <= loss_cnt_d;
                    end
                    ST_FLUSH: begin
                        // Flush is held for exactly two cycles before retraining.
                        if (!flush_cnt_q) begin
                            flush_cnt_q <= 1'b1;
                        end else begin
                            flush_cnt_q  <= 1'b0;
                            fifo_rst_n_q <= 1'b1;
                            state_q      <= bus.link_en ? ST_COUNT : ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.window_cnt = window_cnt_q;
    assign bus.r_en       = (state_q == ST_ALIGNED) & (&bus.fifo_not_empty);
    assign bus.fifo_rst_n = fifo_rst_n_q;
    assign bus.aligned    = aligned_q;
    assign bus.deskew_err = deskew_err_q;
    assign bus.skew_max   = skew_max_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_deskew_ctrl.sv
// Directed bench for deskew_ctrl: bring-up, skew measurement, overflow, loss of
// alignment, link drop, asynchronous reset and error-counter saturation.
module tb_deskew_ctrl;

    localparam int NL = 4;
    localparam int MS = 3;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rstn;
    int   n_total = 0;
    int   n_bad   = 0;
    int   pulses  = 0;

    deskew_ctrl_if #(.NUM_LANES(NL), .SKW(SW)) bus ();

    deskew_ctrl #(
        .NUM_LANES(NL),
        .MAX_SKEW (MS),
        .SKW      (SW)
    ) dut (
        .clk_r_local(clk),
        .rstn       (rstn),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_window"},  32'(bus.window_cnt), 32'd0);
        chk({tag, "_ren"},     32'(bus.r_en),       32'd0);
        chk({tag, "_frst"},    32'(bus.fifo_rst_n), 32'd1);
        chk({tag, "_aligned"}, 32'(bus.aligned),    32'd0);
        chk({tag, "_err"},     32'(bus.deskew_err), 32'd0);
        chk({tag, "_skewmax"}, 32'(bus.skew_max),   32'd0);
        chk({tag, "_errcnt"},  32'(bus.err_cnt),    32'd0);
    endtask

    // Bounded wait for the first HUNT cycle; a timeout shows up as a failed check.
    task automatic wait_w4(input string tag);
        for (int i = 0; i < 20 && bus.window_cnt != 3'd4; i++) begin
            tick();
        end
        chk(tag, 32'(bus.window_cnt), 32'd4);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn               = 1'b0;
        bus.link_en        = 1'b0;
        bus.com_ahead      = '0;
        bus.fifo_not_empty = '0;
        repeat (3) tick();
        chk_reset("rst");
        rstn = 1'b1;
        tick();
        chk("idle_hold_w", 32'(bus.window_cnt), 32'd0);

        // Bring-up, all lanes COM together
        bus.link_en = 1'b1;
        tick(); chk("cnt_w0", 32'(bus.window_cnt), 32'd0);
        tick(); chk("cnt_w1", 32'(bus.window_cnt), 32'd1);
        tick(); chk("cnt_w2", 32'(bus.window_cnt), 32'd2);
        tick(); chk("cnt_w3", 32'(bus.window_cnt), 32'd3);
        tick(); chk("cnt_w4", 32'(bus.window_cnt), 32'd4);
        bus.fifo_not_empty = 4'hF;
        #1 chk("hunt_ren0", 32'(bus.r_en), 32'd0);
        bus.com_ahead = 4'hF;
        tick();
        bus.com_ahead = 4'h0;
        chk("s1_aligned", 32'(bus.aligned),  32'd1);
        chk("s1_skewmax", 32'(bus.skew_max), 32'd0);
        chk("s1_ren",     32'(bus.r_en),     32'd1);
        bus.fifo_not_empty = 4'h0;
        #1 chk("s1_ren_empty", 32'(bus.r_en), 32'd0);
        bus.fifo_not_empty = 4'hF;
        #1 chk("s1_ren_full", 32'(bus.r_en), 32'd1);

        // Link drop from ALIGNED: two flush cycles then IDLE
        bus.link_en = 1'b0;
        tick();
        chk("ld_frst_c1", 32'(bus.fifo_rst_n), 32'd0);
        chk("ld_aligned", 32'(bus.aligned),    32'd0);
        chk("ld_err",     32'(bus.deskew_err), 32'd0);
        chk("ld_ren",     32'(bus.r_en),       32'd0);
        tick(); chk("ld_frst_c2", 32'(bus.fifo_rst_n), 32'd0);
        tick(); chk("ld_frst_hi", 32'(bus.fifo_rst_n), 32'd1);
        chk("ld_idle_w", 32'(bus.window_cnt), 32'd0);

        // Staggered arrivals t0, t0+1, t0+3, t0+2 -> skew 3
        bus.link_en = 1'b1;
        wait_w4("s2_w4");
        bus.com_ahead = 4'b0001; tick();
        bus.com_ahead = 4'b0010; tick();
        bus.com_ahead = 4'b1000; tick();
        bus.com_ahead = 4'b0100;
        chk("s2_pre_al", 32'(bus.aligned), 32'd0);
        tick();
        bus.com_ahead = 4'b0000;
        chk("s2_aligned", 32'(bus.aligned),    32'd1);
        chk("s2_skewmax", 32'(bus.skew_max),   32'd3);
        chk("s2_noerr",   32'(bus.deskew_err), 32'd0);
        chk("s2_errcnt",  32'(bus.err_cnt),    32'd0);
        chk("s2_ren",     32'(bus.r_en),       32'd1);

        // Lane 2 empty for 3 cycles: tolerated
        bus.fifo_not_empty = 4'b1011;
        #1 chk("l3_ren_c0", 32'(bus.r_en), 32'd0);
        tick(); chk("l3_ren_c1", 32'(bus.r_en), 32'd0);
        tick(); tick();
        chk("l3_err",     32'(bus.deskew_err), 32'd0);
        chk("l3_aligned", 32'(bus.aligned),    32'd1);
        bus.fifo_not_empty = 4'hF;
        #1 chk("l3_ren_back", 32'(bus.r_en), 32'd1);
        tick();

        // Lane 2 empty for 4 cycles: loss of alignment
        bus.fifo_not_empty = 4'b1011;
        tick(); tick(); tick();
        chk("l4_pre_err", 32'(bus.deskew_err), 32'd0);
        chk("l4_pre_al",  32'(bus.aligned),    32'd1);
        chk("l4_pre_ren", 32'(bus.r_en),       32'd0);
        tick();
        chk("l4_err",     32'(bus.deskew_err), 32'd1);
        chk("l4_frst",    32'(bus.fifo_rst_n), 32'd0);
        chk("l4_aligned", 32'(bus.aligned),    32'd0);
        chk("l4_errcnt",  32'(bus.err_cnt),    32'd1);
        bus.fifo_not_empty = 4'hF;
        #1 chk("l4_ren_flush", 32'(bus.r_en), 32'd0);
        tick();
        chk("l4_err_off", 32'(bus.deskew_err), 32'd0);
        chk("l4_frst_c2", 32'(bus.fifo_rst_n), 32'd0);
        tick();
        chk("l4_frst_hi", 32'(bus.fifo_rst_n), 32'd1);
        chk("l4_w0",      32'(bus.window_cnt), 32'd0);
        wait_w4("l4_w4");

        // Skew overflow: lane 3 arrives at t0+4
        bus.fifo_not_empty = 4'h0;
        bus.com_ahead = 4'b0111; tick();
        bus.com_ahead = 4'b0000; tick(); tick();
        chk("ov_pre_err", 32'(bus.deskew_err), 32'd0);
        tick();
        chk("ov_err",     32'(bus.deskew_err), 32'd1);
        chk("ov_errcnt",  32'(bus.err_cnt),    32'd2);
        chk("ov_frst",    32'(bus.fifo_rst_n), 32'd0);
        chk("ov_w0",      32'(bus.window_cnt), 32'd0);
        chk("ov_aligned", 32'(bus.aligned),    32'd0);
        bus.com_ahead = 4'b1000;
        tick();
        chk("ov_err_off", 32'(bus.deskew_err), 32'd0);
        chk("ov_frst_c2", 32'(bus.fifo_rst_n), 32'd0);
        bus.com_ahead = 4'b0000;
        tick();
        chk("ov_frst_hi", 32'(bus.fifo_rst_n), 32'd1);
        wait_w4("ov_w4");

        // Link drop mid-HUNT
        bus.com_ahead = 4'b0001; tick();
        bus.com_ahead = 4'b0000;
        bus.link_en   = 1'b0;
        tick();
        chk("lh_frst",   32'(bus.fifo_rst_n), 32'd0);
        chk("lh_err",    32'(bus.deskew_err), 32'd0);
        chk("lh_errcnt", 32'(bus.err_cnt),    32'd2);
        chk("lh_w0",     32'(bus.window_cnt), 32'd0);
        tick(); chk("lh_frst_c2", 32'(bus.fifo_rst_n), 32'd0);
        tick(); chk("lh_frst_hi", 32'(bus.fifo_rst_n), 32'd1);
        tick(); chk("lh_idle_w",  32'(bus.window_cnt), 32'd0);

        // Asynchronous reset while ALIGNED
        bus.link_en = 1'b1;
        bus.fifo_not_empty = 4'hF;
        wait_w4("ar_w4");
        bus.com_ahead = 4'hF; tick();
        bus.com_ahead = 4'h0;
        chk("ar_aligned", 32'(bus.aligned), 32'd1);
        chk("ar_ren",     32'(bus.r_en),    32'd1);
        #2 rstn = 1'b0;
        #1 chk_reset("arst");
        tick();
        rstn = 1'b1;

        // Drive 300 overflow errors; err_cnt must track then saturate at 255
        bus.fifo_not_empty = 4'h0;
        bus.com_ahead      = 4'b0001;
        pulses = 0;
        for (int c = 0; c < 3400 && pulses < 300; c++) begin
            tick();
            if (bus.deskew_err) begin
                pulses++;
                chk("sat_errcnt", 32'(bus.err_cnt), (pulses > 255) ? 32'd255 : 32'(pulses));
            end
        end
        chk("sat_pulses", 32'(pulses),      32'd300);
        chk("sat_final",  32'(bus.err_cnt), 32'd255);

        // Error and link drop in the same cycle: error is reported, then IDLE
        wait_w4("el_w4");
        tick(); tick(); tick();
        bus.link_en = 1'b0;
        tick();
        chk("el_err",    32'(bus.deskew_err), 32'd1);
        chk("el_errcnt", 32'(bus.err_cnt),    32'd255);
        tick(); tick();
        chk("el_frst_hi", 32'(bus.fifo_rst_n), 32'd1);
        chk("el_w0",      32'(bus.window_cnt), 32'd0);
        tick();
        chk("el_idle_w",  32'(bus.window_cnt), 32'd0);
        chk("el_aligned", 32'(bus.aligned),    32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
